dram_responder: RTL and testbench

DRAM_RESPONDER -- requirements
Module: dram_responder

---
 rtl/dram_responder_if.sv | 28 ++
 rtl/dram_responder.sv | 111 +++++++++++
 tb/tb_dram_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_responder_if.sv
// Handshake bundle between the core's dramra/dramrd/dramw ports and the DRAM responder.
// master = core side, slave = responder side.
interface dram_responder_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) ();
    logic            ra_rdy;
    logic            ra_ack;
    logic [AW-1:0]   i_ra_addr;
    logic            rd_rdy;
    logic            rd_ack;
    logic [DW-1:0]   o_rd_data;
    logic            w_rdy;
    logic            w_ack;
    logic [AW-1:0]   i_w_addr;
    logic [DW-1:0]   i_w_data;
    logic [DW/8-1:0] i_w_mask;

    modport master (
        output ra_rdy, i_ra_addr, rd_ack, w_rdy, i_w_addr, i_w_data, i_w_mask,
        input  ra_ack, rd_rdy, o_rd_data, w_ack
    );

    modport slave (
        input  ra_rdy, i_ra_addr, rd_ack, w_rdy, i_w_addr, i_w_data, i_w_mask,
        output ra_ack, rd_rdy, o_rd_data, w_ack
    );
endinterface

// File: rtl/dram_responder.sv
// DRAM-side responder: byte-masked writes, in-order reads through a fixed-latency
// pipeline into a return FIFO, with credit-limited read acceptance and R/W round-robin.
module dram_responder #(
    parameter int unsigned AW  = 10,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 4,
    parameter int unsigned QD  = 4
) (
    input logic             i_clk,
    input logic             i_rst,
    dram_responder_if.slave bus
);
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned Words = 1 << AW;
    localparam int unsigned CW    = $clog2(QD + 1);
    localparam int unsigned PW    = (QD > 1) ? $clog2(QD) : 1;

    logic [DW-1:0] mem_q [Words];

    logic          rr_q, rr_d;
    logic [CW-1:0] out_q, out_d;
    logic          pipe_v_q [LAT];
    logic          pipe_v_d [LAT];
    logic [DW-1:0] pipe_dat_q [LAT];
    logic [DW-1:0] pipe_dat_d [LAT];
    logic [DW-1:0] fifo_q [QD];
    logic [DW-1:0] fifo_d [QD];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic ra_xfer, w_xfer, rd_xfer, contended, credit_ok, push, rd_rdy;

    // Reads win a contended cycle only when rr says so and a credit is free;
    // otherwise the write takes the slot. Acks are forced low while in reset.
    always_comb begin
        contended = bus.ra_rdy && bus.w_rdy;
        credit_ok = (out_q < CW'(QD));
        ra_xfer   = i_rst && bus.ra_rdy && credit_ok && (!bus.w_rdy || !rr_q);
        w_xfer    = i_rst && bus.w_rdy && !ra_xfer;
        rd_rdy    = (cnt_q != '0);
        rd_xfer   = rd_rdy && bus.rd_ack;
        push      = pipe_v_q[LAT-1];
    end

    assign bus.ra_ack    = ra_xfer;
    assign bus.w_ack     = w_xfer;
    assign bus.rd_rdy    = rd_rdy;
    assign bus.o_rd_data = rd_rdy ? fifo_q[rd_ptr_q] : '0;

    always_comb begin
        rr_d  = rr_q;
        out_d = out_q + CW'(ra_xfer) - CW'(rd_xfer);
        if (contended && (ra_xfer || w_xfer)) begin
            rr_d = !rr_q;
        end

        pipe_v_d[0]   = ra_xfer;
        pipe_dat_d[0] = ra_xfer ? mem_q[bus.i_ra_addr] : '0;
        for (int i = 1; i < LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end

        // Credits bound pipeline + FIFO occupancy, so a push never meets a full FIFO.
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(rd_xfer);
        if (push) begin
            fifo_d[wr_ptr_q] = pipe_dat_q[LAT-1];
            wr_ptr_d = (wr_ptr_q == PW'(QD - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_xfer) begin
            rd_ptr_d = (rd_ptr_q == PW'(QD - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rr_q       <= 1'b0;
            out_q      <= '0;
            pipe_v_q   <= '{default: 1'b0};
            pipe_dat_q <= '{default: '0};
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            out_q      <= out_d;
            pipe_v_q   <= pipe_v_d;
            pipe_dat_q <= pipe_dat_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage is deliberately not reset so completed writes survive a reset.
    always_ff @(posedge i_clk) begin
        if (w_xfer) begin
            for (int b = 0; b < BW; b++) begin
                if (bus.i_w_mask[b]) begin
                    mem_q[bus.i_w_addr][8*b +: 8] <= bus.i_w_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: directed scenarios plus a randomized
// traffic run checked against a word-array memory model and an expected-data queue.
module tb_dram_responder;
    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 4;
    localparam int unsigned QD  = 4;

    logic i_clk;
    logic i_rst;

    dram_responder_if #(.AW(AW), .DW(DW)) bus ();

    dram_responder #(.AW(AW), .DW(DW), .LAT(LAT), .QD(QD)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors;
    int miscompares;
    logic [DW-1:0] model_mem [1 << AW];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [DW/8-1:0] mask);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW / 8; b++) if (mask[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        bus.ra_rdy = 0; bus.i_ra_addr = '0; bus.rd_ack = 0;
        bus.w_rdy = 0; bus.i_w_addr = '0; bus.i_w_data = '0; bus.i_w_mask = '0;
    endtask

    task automatic apply_reset();
        i_rst = 0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW/8-1:0] m);
        int n;
        bus.w_rdy = 1; bus.i_w_addr = a; bus.i_w_data = d; bus.i_w_mask = m;
        n = 0;
        @(negedge i_clk);
        while (!bus.w_ack && n < 20) begin @(negedge i_clk); n++; end
        vectors++;
        if (!bus.w_ack) begin
            miscompares++;
            $display("FAIL write_accept addr=%0d: w_ack=%b required 1", a, bus.w_ack);
        end else begin
            model_mem[a] = merge(model_mem[a], d, m);
        end
        @(posedge i_clk); #1 bus.w_rdy = 0;
    endtask

    // Returns with ra_rdy dropped, #1 after the transfer edge.
    task automatic issue_read(input logic [AW-1:0] a);
        int n;
        bus.ra_rdy = 1; bus.i_ra_addr = a;
        n = 0;
        @(negedge i_clk);
        while (!bus.ra_ack && n < 20) begin @(negedge i_clk); n++; end
        vectors++;
        if (!bus.ra_ack) begin
            miscompares++;
            $display("FAIL read_accept addr=%0d: ra_ack=%b required 1", a, bus.ra_ack);
        end
        @(posedge i_clk); #1 bus.ra_rdy = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rst = 0;
        #2;
        bus.ra_rdy = 1; bus.w_rdy = 1; bus.rd_ack = 1;
        repeat (2) @(negedge i_clk);
        vectors++;
        if ({bus.ra_ack, bus.w_ack, bus.rd_rdy} !== 3'b000 || bus.o_rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ra_ack=%b w_ack=%b rd_rdy=%b data=%h required 0",
                     bus.ra_ack, bus.w_ack, bus.rd_rdy, bus.o_rd_data);
        end
        idle_inputs();
        @(posedge i_clk); #1 i_rst = 1;
    endtask

    task automatic test_write_read();
        int n;
        do_write(10'd5, 32'hDEADBEEF, 4'hF);
        bus.rd_ack = 1;
        issue_read(10'd5);
        n = 0;
        while (!bus.rd_rdy && n < 20) begin @(posedge i_clk); #1; n++; end
        vectors++;
        if (n != LAT) begin
            miscompares++;
            $display("FAIL read_latency: got %0d cycles required %0d", n, LAT);
        end
        vectors++;
        if (bus.o_rd_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL read_data_addr5: got %h required deadbeef", bus.o_rd_data);
        end
        @(posedge i_clk); #1 bus.rd_ack = 0;
        vectors++;
        if (bus.rd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_empty: rd_rdy=%b required 0", bus.rd_rdy);
        end
    endtask

    task automatic test_masked_write();
        int n;
        do_write(10'd7, 32'h11223344, 4'hF);
        do_write(10'd7, 32'hAABBCCDD, 4'h5);
        do_write(10'd7, 32'h55555555, 4'h0);
        bus.rd_ack = 1;
        issue_read(10'd7);
        n = 0;
        while (!bus.rd_rdy && n < 20) begin @(posedge i_clk); #1; n++; end
        vectors++;
        if (bus.o_rd_data !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL masked_write: got %h required 11bb33dd", bus.o_rd_data);
        end
        @(posedge i_clk); #1 bus.rd_ack = 0;
    endtask

    task automatic test_credit_limit();
        int accepted;
        int n;
        logic [DW-1:0] exp_q [$];
        for (int i = 0; i < 6; i++) do_write(AW'(100 + i), $urandom, 4'hF);
        bus.rd_ack = 0;
        accepted = 0;
        bus.ra_rdy = 1; bus.i_ra_addr = AW'(100);
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (bus.ra_ack) begin
                exp_q.push_back(model_mem[bus.i_ra_addr]);
                accepted++;
                @(posedge i_clk); #1 bus.i_ra_addr = AW'(100 + accepted);
            end else begin
                @(posedge i_clk); #1;
            end
        end
        vectors++;
        if (accepted != QD) begin
            miscompares++;
            $display("FAIL credit_accepts: got %0d required %0d", accepted, QD);
        end
        bus.rd_ack = 1;
        @(negedge i_clk);
        vectors++;
        if (bus.ra_ack !== 1'b0 || bus.rd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_hold: ra_ack=%b rd_rdy=%b required 0/1", bus.ra_ack, bus.rd_rdy);
        end
        @(posedge i_clk); #1 bus.rd_ack = 0;
        @(negedge i_clk);
        vectors++;
        if (bus.ra_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_return: ra_ack=%b required 1", bus.ra_ack);
        end else begin
            exp_q.push_back(model_mem[bus.i_ra_addr]);
        end
        @(posedge i_clk); #1 bus.ra_rdy = 0; bus.rd_ack = 1;
        // First entry was already popped above.
        void'(exp_q.pop_front());
        while (exp_q.size() > 0) begin
            n = 0;
            while (!bus.rd_rdy && n < 30) begin @(posedge i_clk); #1; n++; end
            vectors++;
            if (bus.o_rd_data !== exp_q[0]) begin
                miscompares++;
                $display("FAIL credit_order: got %h required %h", bus.o_rd_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(posedge i_clk); #1;
        end
        bus.rd_ack = 0;
    endtask

    task automatic test_arbitration();
        string got;
        string exp;
        idle_inputs();
        apply_reset();
        bus.rd_ack = 1;
        bus.ra_rdy = 1; bus.i_ra_addr = AW'(200);
        bus.w_rdy = 1; bus.i_w_addr = AW'(201); bus.i_w_data = 32'h0BADF00D; bus.i_w_mask = 4'hF;
        got = ""; exp = "";
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            exp = {exp, (i % 2 == 0) ? "R" : "W"};
            if (bus.ra_ack && bus.w_ack) got = {got, "B"};
            else if (bus.ra_ack) got = {got, "R"};
            else if (bus.w_ack) got = {got, "W"};
            else got = {got, "-"};
            @(posedge i_clk); #1;
        end
        model_mem[201] = 32'h0BADF00D;
        bus.ra_rdy = 0; bus.w_rdy = 0;
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL arbitration: got %s required %s", got, exp);
        end
        repeat (LAT + 6) @(posedge i_clk);
        #1 bus.rd_ack = 0;
    endtask

    task automatic test_reset_midflight();
        int n;
        do_write(10'd300, 32'hC0FFEE42, 4'hF);
        bus.rd_ack = 0;
        for (int i = 0; i < 3; i++) issue_read(10'd300);
        #2 i_rst = 0;
        #1;
        vectors++;
        if (bus.rd_rdy !== 1'b0 || bus.o_rd_data !== '0) begin
            miscompares++;
            $display("FAIL midflight_reset: rd_rdy=%b data=%h required 0", bus.rd_rdy, bus.o_rd_data);
        end
        @(posedge i_clk); #1 i_rst = 1;
        repeat (LAT + 3) @(posedge i_clk);
        #1;
        vectors++;
        if (bus.rd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_data: rd_rdy=%b required 0", bus.rd_rdy);
        end
        bus.rd_ack = 0;
        n = 0;
        for (int i = 0; i < QD; i++) begin
            bus.ra_rdy = 1; bus.i_ra_addr = 10'd300;
            @(negedge i_clk);
            if (bus.ra_ack) n++;
            @(posedge i_clk); #1 bus.ra_rdy = 0;
        end
        vectors++;
        if (n != QD) begin
            miscompares++;
            $display("FAIL credits_after_reset: accepted %0d required %0d", n, QD);
        end
        bus.rd_ack = 1;
        repeat (LAT + QD + 2) @(posedge i_clk);
        #1;
        bus.rd_ack = 1;
        issue_read(10'd300);
        n = 0;
        while (!bus.rd_rdy && n < 20) begin @(posedge i_clk); #1; n++; end
        vectors++;
        if (n != LAT || bus.o_rd_data !== 32'hC0FFEE42) begin
            miscompares++;
            $display("FAIL fresh_read: latency %0d data %h required %0d/c0ffee42",
                     n, bus.o_rd_data, LAT);
        end
        @(posedge i_clk); #1 bus.rd_ack = 0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q [$];
        int outstanding;
        int n;
        idle_inputs();
        for (int a = 0; a < 16; a++) do_write(AW'(a), $urandom, 4'hF);
        outstanding = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge i_clk);
            vectors++;
            if (bus.ra_ack && bus.w_ack) begin
                miscompares++;
                $display("FAIL rand_exclusive cycle %0d: both acks high", c);
            end
            if (outstanding >= QD) begin
                vectors++;
                if (bus.ra_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_credit cycle %0d: ra_ack=1 with %0d outstanding",
                             c, outstanding);
                end
            end
            if (bus.rd_rdy && bus.rd_ack) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_spurious: got %h required no data", bus.o_rd_data);
                end else begin
                    if (bus.o_rd_data !== exp_q[0]) begin
                        miscompares++;
                        $display("FAIL rand_data: got %h required %h", bus.o_rd_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                outstanding--;
            end
            if (bus.w_ack) model_mem[bus.i_w_addr] =
                merge(model_mem[bus.i_w_addr], bus.i_w_data, bus.i_w_mask);
            if (bus.ra_ack) begin
                exp_q.push_back(model_mem[bus.i_ra_addr]);
                outstanding++;
            end
            @(posedge i_clk); #1;
            if (bus.ra_ack || !bus.ra_rdy) begin
                bus.ra_rdy = (c < 560) && ($urandom_range(0, 9) < 5);
                bus.i_ra_addr = AW'($urandom_range(0, 15));
            end
            if (bus.w_ack || !bus.w_rdy) begin
                bus.w_rdy = (c < 560) && ($urandom_range(0, 9) < 4);
                bus.i_w_addr = AW'($urandom_range(0, 15));
                bus.i_w_data = $urandom;
                bus.i_w_mask = 4'($urandom);
            end
            bus.rd_ack = (c >= 560) || ($urandom_range(0, 9) < 6);
        end
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge i_clk); n++;
        end
        vectors++;
        if (exp_q.size() != 0 || bus.rd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain: %0d reads pending rd_rdy=%b required 0/0",
                     exp_q.size(), bus.rd_rdy);
        end
        idle_inputs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_inputs();
        i_rst = 0;
        test_reset();
        test_write_read();
        test_masked_write();
        test_credit_limit();
        test_arbitration();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
